wisard_serial_deser: RTL

Parametrised serial front-end for the WiSARD classifier. Accepts per-RAM addresses streamed LANES bits per beat, rebuilds each ADDRESS_WIDTH-bit address with its RAM index, and emits one parallel word per RAM with sop/eop framing to the wisard core. Generalises the existing 1-bit serial input path to multi-lane, selectable bit order, and a valid-qualified (stallable) mode. Adds frame checking with an error flag.

---
 rtl/wisard_serial_deser.sv | 99 +++++++++
 1 files changed

// File: rtl/wisard_serial_deser.sv
// wisard_serial_deser: serial lane deserializer that turns beats into framed per-RAM address words
module wisard_serial_deser #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int INDEX_WIDTH   = 8,
    parameter int N_RAMS        = 64,
    parameter int LANES         = 1,
    parameter int QUALIFIED     = 0,
    parameter int MSB_FIRST     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sink_sop,
    input  logic                     sink_valid,
    input  logic                     sink_eop,
    input  logic [LANES-1:0]         sink_data,
    output logic                     source_sop,
    output logic                     source_valid,
    output logic                     source_eop,
    output logic [ADDRESS_WIDTH-1:0] source_addr,
    output logic [INDEX_WIDTH-1:0]   source_index,
    output logic                     frame_err,
    output logic                     busy
);
    localparam int BEATS = ADDRESS_WIDTH / LANES;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_WORD = INDEX_WIDTH'(N_RAMS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, NEXT, EOP_WAIT} state_t;

    state_t                   state;
    logic [BW-1:0]            beat, beat_sel, slot;
    logic [INDEX_WIDTH-1:0]   word, word_sel;
    logic [ADDRESS_WIDTH-1:0] acc, asm_addr;
    logic                     start, bad_eop, take, err;

    always_comb begin
        start    = sink_valid & sink_sop;
        bad_eop  = sink_eop & (state != EOP_WAIT);
        take     = start | (!bad_eop & ((state == SHIFT & (sink_valid == (QUALIFIED != 0)))
                                      | (state == NEXT & sink_valid)));
        err      = start ? (state != IDLE) | sink_eop
                         : bad_eop | (state == IDLE & sink_valid)
                           | (state == SHIFT & QUALIFIED == 0 & sink_valid)
                           | (state == EOP_WAIT & !sink_eop);
        beat_sel = start ? '0 : beat;
        word_sel = start ? '0 : word;
        slot     = MSB_FIRST != 0 ? LAST_BEAT - beat_sel : beat_sel;
        asm_addr = acc;
        asm_addr[slot*LANES +: LANES] = sink_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat         <= '0;
            word         <= '0;
            acc          <= '0;
            source_sop   <= 1'b0;
            source_valid <= 1'b0;
            source_eop   <= 1'b0;
            source_addr  <= '0;
            source_index <= '0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            source_sop   <= 1'b0;
            source_valid <= 1'b0;
            source_eop   <= 1'b0;
            source_addr  <= '0;
            source_index <= '0;
            frame_err    <= err;
            if (take) begin
                acc  <= asm_addr;
                busy <= 1'b1;
                word <= word_sel;
                if (beat_sel == LAST_BEAT) begin
                    source_valid <= 1'b1;
                    source_addr  <= asm_addr;
                    source_index <= word_sel;
                    source_sop   <= word_sel == '0;
                    source_eop   <= word_sel == LAST_WORD;
                    beat         <= '0;
                    state        <= word_sel == LAST_WORD ? EOP_WAIT : NEXT;
                    if (word_sel != LAST_WORD)
                        word <= word_sel + 1'b1;
                end else begin
                    beat  <= beat_sel + 1'b1;
                    state <= SHIFT;
                end
            end else if (err || state == EOP_WAIT) begin
                state <= IDLE;
                beat  <= '0;
                word  <= '0;
                busy  <= 1'b0;
            end
        end
    end
endmodule
